stream_upsizer: RTL and testbench
=================================

STREAM_UPSIZER -- requirements
Module: stream_upsizer

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 32, width of one input beat (≥1).
REQ-002 SHALL have parameter RATIO, default 4, input beats per output word (≥2, power of 2).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port data_i  input  IN_WIDTH  input beat, sourced from the FIFO pop side.
REQ-006 SHALL have port valid_i  input  1  input beat valid.
REQ-007 SHALL have port last_i  input  1  beat closes current word (flush partial).
REQ-008 SHALL have port grant_o  output  1  block accepts input beat this cycle.
REQ-009 SHALL have port data_o  output  IN_WIDTH*RATIO  packed word; lane k = bits [k*IN_WIDTH +: IN_WIDTH].
REQ-010 SHALL have port strb_o  output  RATIO  lane-valid mask of data_o.
REQ-011 SHALL have port last_o  output  1  word was closed by last_i.
REQ-012 SHALL have port valid_o  output  1  packed word valid.
REQ-013 SHALL have port grant_i  input  1  downstream accepts packed word.

Function
REQ-014 SHALL transfer input beat only when valid_i && grant_o; output word only when valid_o && grant_i.
REQ-015 SHALL keep an accumulator with states EMPTY (no lanes), COLLECT (1..RATIO-1 lanes), HELD (complete word awaiting output slot), plus lane counter cnt (log2 RATIO bits).
REQ-016 SHALL write accepted beat to lane cnt, set strb bit cnt, increment cnt; first beat lands in lane 0.
REQ-017 SHALL complete word when accepted beat has cnt==RATIO-1 or last_i=1; cnt returns to 0 (wrap, no overflow).
REQ-018 SHALL move a completing word into the output register on the same accepting edge if output slot free (valid_o==0 or grant_i==1); otherwise accumulator enters HELD.
REQ-019 SHALL drive grant_o = 1 in EMPTY/COLLECT, 0 in HELD.
REQ-020 SHALL move HELD word into output register on first edge where slot free; accumulator returns to EMPTY, grant_o high next cycle.
REQ-021 SHALL clear accumulator lanes and strb to 0 when a word moves out; unfilled lanes of partial words read as 0 with strb bit 0.
REQ-022 SHALL set last_o = last_i of the completing beat, registered with the word.
REQ-023 SHALL assert valid_o one cycle after the completing beat edge (latency 1) when slot free.
REQ-024 SHALL hold data_o, strb_o, last_o, valid_o stable while valid_o && !grant_i; valid_o never withdrawn before handshake.
REQ-025 SHALL sustain one input beat per cycle under continuous grant_i=1 (one output word per RATIO cycles, no bubbles).
REQ-026 SHALL handle simultaneous output handshake and word completion in same cycle: old word leaves, new word loads, valid_o stays 1.
REQ-027 SHALL ignore last_i and data_i when valid_i=0; last_i on lane 0 yields word with strb_o=1 (single lane).
REQ-028 SHALL be purely registered on data_o/strb_o/last_o/valid_o; grant_o SHALL depend on registered state only (no combinational path from grant_i).

Reset
REQ-029 SHALL on rst=1, immediately and asynchronously: accumulator EMPTY, cnt=0, lanes=0, valid_o=0, data_o=0, strb_o=0, last_o=0; grant_o=1 after release.
REQ-030 SHALL discard any partial or HELD word when reset asserts mid-operation; no word emitted after release until new beats arrive.

Verification
REQ-031 SHALL cover: beats 0x11,0x22,0x33,0x44 back-to-back, grant_i=1 -> data_o=0x00000044_00000033_00000022_00000011, strb_o=4'hF, last_o=0, valid_o one cycle after 4th beat.
REQ-032 SHALL cover: beats 0xA,0xB with last_i on 2nd -> data_o lanes 0..1=0xA,0xB, lanes 2..3=0, strb_o=4'h3, last_o=1.
REQ-033 SHALL cover: grant_i=0 while 8 beats offered -> first word in output, second HELD, grant_o=0 after 8th beat; output stable; grant_i=1 releases both in order.
REQ-034 SHALL cover: continuous 64 beats, grant_i=1 -> 16 words, zero input stall cycles, beat order preserved.
REQ-035 SHALL cover: rst pulse after 2 beats of a word -> valid_o=0, next 4 beats form fresh word starting in lane 0.
REQ-036 SHALL cover: random valid_i/grant_i stalls vs reference model -> all words and strb/last match, no loss or duplication.

Source files
------------

// File: rtl/stream_upsizer.sv
// ---------------------------------------------------------------------------
// stream_upsizer
//
// Packs RATIO narrow input beats into one wide output word. Beats fill lanes
// from lane 0 upward; a word closes when the top lane is written or when the
// beat carries last_i, in which case the unfilled lanes stay zero and their
// strobe bits stay clear. A closed word moves into the output register as
// soon as that register is free. Otherwise the word waits in the accumulator
// (HELD), and input is refused until the word can move out.
//
// Parameters
//   IN_WIDTH : width of one input beat (>= 1)
//   RATIO    : input beats per output word (>= 2, power of two)
//
// Ports
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   data_i   : input beat
//   valid_i  : input beat valid
//   last_i   : input beat closes the current word
//   grant_o  : block accepts an input beat this cycle
//   data_o   : packed word, lane k = data_o[k*IN_WIDTH +: IN_WIDTH]
//   strb_o   : lane-valid mask of data_o
//   last_o   : word was closed by last_i
//   valid_o  : packed word valid
//   grant_i  : downstream accepts the packed word
// ---------------------------------------------------------------------------
module stream_upsizer #(
  parameter int IN_WIDTH = 32,
  parameter int RATIO    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [IN_WIDTH-1:0]       data_i,
  input  logic                      valid_i,
  input  logic                      last_i,
  output logic                      grant_o,
  output logic [IN_WIDTH*RATIO-1:0] data_o,
  output logic [RATIO-1:0]          strb_o,
  output logic                      last_o,
  output logic                      valid_o,
  input  logic                      grant_i
);

  localparam int OUT_W = IN_WIDTH * RATIO;
  localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    COLLECT = 2'd1,
    HELD    = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [OUT_W-1:0] acc_data_p0;
  logic [RATIO-1:0] acc_strb_p0;
  logic             acc_last_p0;
  logic [CNT_W-1:0] cnt_p0;

  logic             accept;
  logic             complete;
  logic             slot_free;
  logic             load_out;
  logic [OUT_W-1:0] merged_data;
  logic [RATIO-1:0] merged_strb;
  logic [OUT_W-1:0] word_data;
  logic [RATIO-1:0] word_strb;
  logic             word_last;

  // Returns word with lane replaced by beat; other lanes pass through.
  function automatic logic [OUT_W-1:0] merge_lane(
    input logic [OUT_W-1:0]    word,
    input logic [CNT_W-1:0]    lane,
    input logic [IN_WIDTH-1:0] beat
  );
    logic [OUT_W-1:0] r;
    r = word;
    for (int k = 0; k < RATIO; k++) begin
      if (lane == CNT_W'(k)) begin
        r[k*IN_WIDTH +: IN_WIDTH] = beat;
      end
    end
    return r;
  endfunction

  // ---- input handshake / accumulator merge --------------------------------
  always_comb begin
    accept      = valid_i && grant_o;
    slot_free   = !valid_o || grant_i;
    complete    = accept && (last_i || (cnt_p0 == CNT_W'(RATIO - 1)));
    merged_data = merge_lane(acc_data_p0, cnt_p0, data_i);
    merged_strb = acc_strb_p0 | (RATIO'(1) << cnt_p0);
    // A HELD word never coincides with an accepted beat, since grant_o is low.
    load_out    = slot_free && ((state == HELD) || complete);
    if (state == HELD) begin
      word_data = acc_data_p0;
      word_strb = acc_strb_p0;
      word_last = acc_last_p0;
    end else begin
      word_data = merged_data;
      word_strb = merged_strb;
      word_last = last_i;
    end
  end

  // ---- FSM: state register ------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // ---- FSM: next state ----------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY, COLLECT: begin
        if (complete) begin
          state_nxt = slot_free ? EMPTY : HELD;
        end else if (accept) begin
          state_nxt = COLLECT;
        end
      end
      HELD: begin
        if (slot_free) begin
          state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // ---- FSM: outputs (registered state only, no path from grant_i) ---------
  always_comb begin
    grant_o = (state != HELD);
  end

  // ---- accumulator stage (p0) ---------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_data_p0 <= '0;
      acc_strb_p0 <= '0;
      acc_last_p0 <= 1'b0;
      cnt_p0      <= '0;
    end else if (load_out) begin
      acc_data_p0 <= '0;
      acc_strb_p0 <= '0;
      acc_last_p0 <= 1'b0;
      cnt_p0      <= '0;
    end else if (complete) begin
      acc_data_p0 <= merged_data;
      acc_strb_p0 <= merged_strb;
      acc_last_p0 <= last_i;
      cnt_p0      <= '0;
    end else if (accept) begin
      acc_data_p0 <= merged_data;
      acc_strb_p0 <= merged_strb;
      cnt_p0      <= cnt_p0 + CNT_W'(1);
    end
  end

  // ---- output register stage ----------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_o  <= '0;
      strb_o  <= '0;
      last_o  <= 1'b0;
      valid_o <= 1'b0;
    end else if (load_out) begin
      data_o  <= word_data;
      strb_o  <= word_strb;
      last_o  <= word_last;
      valid_o <= 1'b1;
    end else if (grant_i) begin
      valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_upsizer.sv
`timescale 1ns/1ps
module tb_stream_upsizer;

  localparam int W  = 32;
  localparam int R  = 4;
  localparam int OW = W * R;

  typedef struct packed {
    logic [OW-1:0] data;
    logic [R-1:0]  strb;
    logic          last;
  } word_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  data_i = '0;
  logic          valid_i = 1'b0;
  logic          last_i = 1'b0;
  logic          grant_o;
  logic [OW-1:0] data_o;
  logic [R-1:0]  strb_o;
  logic          last_o;
  logic          valid_o;
  logic          grant_i = 1'b0;

  int checks = 0;
  int errors = 0;
  int stalls = 0;
  int words_out = 0;

  // Reference model: completed words not yet taken downstream, plus the
  // word currently being filled.
  word_t         pend[$];
  logic [OW-1:0] part_data = '0;
  logic [R-1:0]  part_strb = '0;
  int            lane = 0;

  stream_upsizer #(.IN_WIDTH(W), .RATIO(R)) dut (
    .clk     (clk),
    .rst     (rst),
    .data_i  (data_i),
    .valid_i (valid_i),
    .last_i  (last_i),
    .grant_o (grant_o),
    .data_o  (data_o),
    .strb_o  (strb_o),
    .last_o  (last_o),
    .valid_o (valid_o),
    .grant_i (grant_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // At most one word sits in the output register and at most one waits
  // behind it; input is refused only when both places are occupied.
  task automatic compare_outputs();
    check("grant", OW'(grant_o), OW'(pend.size() < 2));
    check("valid", OW'(valid_o), OW'(pend.size() > 0));
    if (pend.size() > 0) begin
      check("data", data_o, pend[0].data);
      check("strb", OW'(strb_o), OW'(pend[0].strb));
      check("last", OW'(last_o), OW'(pend[0].last));
    end
  endtask

  // Called just after a falling edge: drive, advance one clock, check.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic l, input logic g);
    logic  acc, hs;
    word_t w;
    valid_i = v;
    data_i  = d;
    last_i  = l;
    grant_i = g;
    acc = v && (pend.size() < 2);
    hs  = (pend.size() > 0) && g;
    if (v && !grant_o) stalls++;
    @(posedge clk);
    if (hs) begin
      void'(pend.pop_front());
      words_out++;
    end
    if (acc) begin
      part_data[lane*W +: W] = d;
      part_strb[lane] = 1'b1;
      if (l || lane == R - 1) begin
        w.data = part_data;
        w.strb = part_strb;
        w.last = l;
        pend.push_back(w);
        part_data = '0;
        part_strb = '0;
        lane = 0;
      end else begin
        lane++;
      end
    end
    @(negedge clk);
    compare_outputs();
  endtask

  task automatic idle(input logic g, input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, W'($urandom), 1'b1, g);
  endtask

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    check("rst_valid", OW'(valid_o), '0);
    check("rst_data", data_o, '0);
    check("rst_strb", OW'(strb_o), '0);
    check("rst_last", OW'(last_o), '0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_grant", OW'(grant_o), OW'(1));

    // four full beats, back to back
    cycle(1'b1, 32'h11, 1'b0, 1'b1);
    cycle(1'b1, 32'h22, 1'b0, 1'b1);
    cycle(1'b1, 32'h33, 1'b0, 1'b1);
    check("full_lat", OW'(valid_o), '0);
    cycle(1'b1, 32'h44, 1'b0, 1'b1);
    check("full_data", data_o, 128'h00000044_00000033_00000022_00000011);
    check("full_strb", OW'(strb_o), OW'(4'hF));
    check("full_last", OW'(last_o), '0);
    idle(1'b1, 1);

    // partial word flushed by last
    cycle(1'b1, 32'hA, 1'b0, 1'b1);
    cycle(1'b1, 32'hB, 1'b1, 1'b1);
    check("part_data", data_o, 128'h00000000_00000000_0000000B_0000000A);
    check("part_strb", OW'(strb_o), OW'(4'h3));
    check("part_last", OW'(last_o), OW'(1));
    idle(1'b1, 1);

    // single-lane word
    cycle(1'b1, 32'h5A5A, 1'b1, 1'b1);
    check("one_strb", OW'(strb_o), OW'(4'h1));
    idle(1'b1, 1);

    // downstream blocked: one word in output, one held
    for (int i = 0; i < 8; i++) cycle(1'b1, W'(32'h100 + i), 1'b0, 1'b0);
    check("held_grant", OW'(grant_o), '0);
    check("held_data", data_o, 128'h00000103_00000102_00000101_00000100);
    for (int i = 0; i < 3; i++) cycle(1'b1, W'(32'h200 + i), 1'b0, 1'b0);
    check("held_stable", data_o, 128'h00000103_00000102_00000101_00000100);
    cycle(1'b0, '0, 1'b0, 1'b1);
    check("held_second", data_o, 128'h00000107_00000106_00000105_00000104);
    idle(1'b1, 2);

    // continuous stream
    stalls = 0;
    words_out = 0;
    for (int i = 0; i < 64; i++) cycle(1'b1, W'($urandom), 1'b0, 1'b1);
    idle(1'b1, 2);
    check("cont_stalls", OW'(stalls), '0);
    check("cont_words", OW'(words_out), OW'(16));

    // reset mid-word with a word waiting in the output register
    for (int i = 0; i < 4; i++) cycle(1'b1, W'(32'h300 + i), 1'b0, 1'b0);
    cycle(1'b1, 32'h310, 1'b0, 1'b0);
    cycle(1'b1, 32'h311, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check("arst_valid", OW'(valid_o), '0);
    check("arst_data", data_o, '0);
    check("arst_strb", OW'(strb_o), '0);
    pend.delete();
    part_data = '0;
    part_strb = '0;
    lane = 0;
    @(negedge clk);
    rst = 1'b0;
    idle(1'b1, 2);
    cycle(1'b1, 32'h401, 1'b0, 1'b1);
    cycle(1'b1, 32'h402, 1'b0, 1'b1);
    cycle(1'b1, 32'h403, 1'b0, 1'b1);
    cycle(1'b1, 32'h404, 1'b0, 1'b1);
    check("arst_fresh", data_o, 128'h00000404_00000403_00000402_00000401);
    idle(1'b1, 1);

    // random stalls on both sides
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 9) < 7), W'($urandom), ($urandom_range(0, 9) < 2),
            ($urandom_range(0, 9) < 6));
    end
    // drain: any partial word is closed by a last beat, then everything leaves
    cycle(1'b1, W'($urandom), 1'b1, 1'b1);
    idle(1'b1, 4);
    check("drain", OW'(pend.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
